// File: rtl/working_timer_pkg.sv
// Shared definitions for the hood working-time counter and self-clean timer.
package working_timer_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_CLEAN = 1'b1
    } state_e;

    localparam int unsigned DEF_TICKS_PER_SEC = 100;
    localparam int unsigned DEF_CLEAN_SEC     = 180;

    localparam int unsigned FIELD_W  = 6;
    localparam int unsigned REMAIN_W = 8;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 63;

    // Divider width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned ticks);
        return (ticks > 1) ? $clog2(ticks) : 1;
    endfunction

endpackage

// File: rtl/working_timer_sec_tick_gen.sv
// Seconds divider: counts 0..TICKS_PER_SEC-1 while enabled, flags the wrap cycle.
module sec_tick_gen
    import working_timer_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = DEF_TICKS_PER_SEC,
    parameter int unsigned INIT_TICK     = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_wrap_c
);

    localparam int unsigned CNT_W = cnt_width(TICKS_PER_SEC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_wrap_c = i_en && !i_clr && (r_cnt == LAST);

    // Tick counter; clear wins over enable, holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= CNT_W'(INIT_TICK);
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/working_timer.sv
// Working-time accumulator with self-clean countdown.
// Optional: define WORK_TIME_SATURATE_EN to stick at 63:59:59 instead of wrapping.
module working_timer
    import working_timer_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = DEF_TICKS_PER_SEC,
    parameter int unsigned CLEAN_SEC     = DEF_CLEAN_SEC,
    // Preset loaded by reset; zero in normal use.
    parameter int unsigned INIT_HOUR     = 0,
    parameter int unsigned INIT_MIN      = 0,
    parameter int unsigned INIT_SEC      = 0,
    parameter int unsigned INIT_TICK     = 0
) (
    input  logic                clk_100Hz,
    input  logic                rst,
    input  logic                is_working,
    input  logic                clean_start,
    input  logic                clean_abort,
    output logic [FIELD_W-1:0]  working_hour,
    output logic [FIELD_W-1:0]  working_min,
    output logic [FIELD_W-1:0]  working_sec,
    output logic                cleaning,
    output logic [REMAIN_W-1:0] clean_remain_sec,
    output logic                clean_done
);

    state_e              r_state, w_state_nxt;
    logic [FIELD_W-1:0]  r_hour, r_min, r_sec;
    logic [FIELD_W-1:0]  w_hour_nxt, w_min_nxt, w_sec_nxt;
    logic [REMAIN_W-1:0] r_remain, w_remain_nxt;
    logic                r_done, w_done_nxt;

    logic w_accept, w_abort, w_at_max, w_run, w_tick_en, w_tick_clr, w_sec_wrap;

    assign w_accept   = (r_state == ST_ACCUM) && clean_start && !is_working;
    assign w_abort    = (r_state == ST_CLEAN) && clean_abort;
    assign w_at_max   = (r_hour == FIELD_W'(HOUR_MAX)) && (r_min == FIELD_W'(MIN_MAX)) &&
                        (r_sec == FIELD_W'(SEC_MAX));
`ifdef WORK_TIME_SATURATE_EN
    assign w_run      = is_working && !w_at_max;
`else
    assign w_run      = is_working;
`endif
    assign w_tick_en  = (r_state == ST_CLEAN) ? 1'b1 : w_run;
    assign w_tick_clr = w_accept || w_abort;

    sec_tick_gen #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .INIT_TICK     (INIT_TICK)
    ) u_sec_tick_gen (
        .clk      (clk_100Hz),
        .rst      (rst),
        .i_en     (w_tick_en),
        .i_clr    (w_tick_clr),
        .o_wrap_c (w_sec_wrap)
    );

    // State register and registered outputs.
    always_ff @(posedge clk_100Hz) begin
        if (rst) begin
            r_state  <= ST_ACCUM;
            r_hour   <= FIELD_W'(INIT_HOUR);
            r_min    <= FIELD_W'(INIT_MIN);
            r_sec    <= FIELD_W'(INIT_SEC);
            r_remain <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_hour   <= w_hour_nxt;
            r_min    <= w_min_nxt;
            r_sec    <= w_sec_nxt;
            r_remain <= w_remain_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Next-state: time carries in ACCUM, countdown/abort/completion in CLEAN.
    always_comb begin
        w_state_nxt  = r_state;
        w_hour_nxt   = r_hour;
        w_min_nxt    = r_min;
        w_sec_nxt    = r_sec;
        w_remain_nxt = r_remain;
        w_done_nxt   = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                if (w_accept) begin
                    w_state_nxt  = ST_CLEAN;
                    w_remain_nxt = REMAIN_W'(CLEAN_SEC);
                end else if (w_sec_wrap && !(w_at_max && (`ifdef WORK_TIME_SATURATE_EN 1'b1 `else 1'b0 `endif))) begin
                    if (r_sec == FIELD_W'(SEC_MAX)) begin
                        w_sec_nxt = '0;
                        if (r_min == FIELD_W'(MIN_MAX)) begin
                            w_min_nxt  = '0;
                            w_hour_nxt = (r_hour == FIELD_W'(HOUR_MAX)) ? '0 : r_hour + FIELD_W'(1);
                        end else begin
                            w_min_nxt = r_min + FIELD_W'(1);
                        end
                    end else begin
                        w_sec_nxt = r_sec + FIELD_W'(1);
                    end
                end
            end
            ST_CLEAN: begin
                if (clean_abort) begin
                    w_state_nxt  = ST_ACCUM;
                    w_remain_nxt = '0;
                end else if (w_sec_wrap) begin
                    if (r_remain == REMAIN_W'(1)) begin
                        w_state_nxt  = ST_ACCUM;
                        w_remain_nxt = '0;
                        w_hour_nxt   = '0;
                        w_min_nxt    = '0;
                        w_sec_nxt    = '0;
                        w_done_nxt   = 1'b1;
                    end else begin
                        w_remain_nxt = r_remain - REMAIN_W'(1);
                    end
                end
            end
            default: w_state_nxt = ST_ACCUM;
        endcase
    end

    assign working_hour     = r_hour;
    assign working_min      = r_min;
    assign working_sec      = r_sec;
    assign cleaning         = (r_state == ST_CLEAN);
    assign clean_remain_sec = r_remain;
    assign clean_done       = r_done;

endmodule

// File: tb/tb_working_timer.sv
// Directed self-checking bench for working_timer (default and preset instances).
module tb_working_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance stimulus / observation.
    logic       rst = 1'b1, work = 1'b0, start = 1'b0, abort = 1'b0;
    logic [5:0] hour, min, sec;
    logic       cln, done;
    logic [7:0] remain;

    // Preset instances share one stimulus set.
    logic       p_rst = 1'b1, p_work = 1'b0, p_start = 1'b0, p_abort = 1'b0;
    logic [5:0] a_hour, a_min, a_sec, b_hour, b_min, b_sec;
    logic       a_cln, a_done, b_cln, b_done;
    logic [7:0] a_remain, b_remain;

    int n_cmp = 0;
    int n_err = 0;

    working_timer dut (
        .clk_100Hz(clk), .rst(rst), .is_working(work), .clean_start(start), .clean_abort(abort),
        .working_hour(hour), .working_min(min), .working_sec(sec), .cleaning(cln),
        .clean_remain_sec(remain), .clean_done(done)
    );

    working_timer #(.CLEAN_SEC(2), .INIT_MIN(59), .INIT_SEC(59), .INIT_TICK(99)) dut_a (
        .clk_100Hz(clk), .rst(p_rst), .is_working(p_work), .clean_start(p_start),
        .clean_abort(p_abort), .working_hour(a_hour), .working_min(a_min), .working_sec(a_sec),
        .cleaning(a_cln), .clean_remain_sec(a_remain), .clean_done(a_done)
    );

    working_timer #(.INIT_HOUR(63), .INIT_MIN(59), .INIT_SEC(59), .INIT_TICK(99)) dut_b (
        .clk_100Hz(clk), .rst(p_rst), .is_working(p_work), .clean_start(p_start),
        .clean_abort(p_abort), .working_hour(b_hour), .working_min(b_min), .working_sec(b_sec),
        .cleaning(b_cln), .clean_remain_sec(b_remain), .clean_done(b_done)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges; land on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, "_h"}, int'(hour), h);
        check({tag, "_m"}, int'(min), m);
        check({tag, "_s"}, int'(sec), s);
    endtask

    initial begin
        step(2);
        // Reset state.
        check_time("rst", 0, 0, 0);
        check("rst_cln", int'(cln), 0);
        check("rst_rem", int'(remain), 0);
        check("rst_done", int'(done), 0);

        // Preset instances: carries and top-of-range behaviour.
        check("a_rst_m", int'(a_min), 59);
        check("a_rst_s", int'(a_sec), 59);
        p_rst = 1'b0; p_work = 1'b1;
        step(1);
        check("a_carry_h", int'(a_hour), 1);
        check("a_carry_m", int'(a_min), 0);
        check("a_carry_s", int'(a_sec), 0);
`ifdef WORK_TIME_SATURATE_EN
        check("b_top_h", int'(b_hour), 63);
        check("b_top_m", int'(b_min), 59);
        check("b_top_s", int'(b_sec), 59);
        step(100);
        check("b_hold_s", int'(b_sec), 59);
        check("b_hold_h", int'(b_hour), 63);
`else
        check("b_top_h", int'(b_hour), 0);
        check("b_top_m", int'(b_min), 0);
        check("b_top_s", int'(b_sec), 0);
        step(100);
        check("b_after_s", int'(b_sec), 1);
        check("b_after_h", int'(b_hour), 0);
`endif
        // Abort in the same cycle as the final decrement wins (dut_a at 01:00:01).
        p_work = 1'b0; p_start = 1'b1;
        step(1);
        p_start = 1'b0;
        check("a_cln", int'(a_cln), 1);
        check("a_rem2", int'(a_remain), 2);
        step(199);
        check("a_rem1", int'(a_remain), 1);
        p_abort = 1'b1;
        step(1);
        p_abort = 1'b0;
        check("a_ab_cln", int'(a_cln), 0);
        check("a_ab_rem", int'(a_remain), 0);
        check("a_ab_done", int'(a_done), 0);
        check("a_ab_h", int'(a_hour), 1);
        check("a_ab_s", int'(a_sec), 1);
        step(1);
        check("a_ab_done2", int'(a_done), 0);

        // Main instance: first-second latency and minute carry.
        rst = 1'b0; work = 1'b1;
        step(100);
        check_time("lat100", 0, 0, 1);
        step(5900);
        check_time("t6000", 0, 1, 0);
        step(1);
        check_time("t6001", 0, 1, 0);
        step(99);
        check_time("t6100", 0, 1, 1);

        // Partial second survives a pause.
        step(50);
        work = 1'b0;
        step(200);
        check("pause_s", int'(sec), 1);
        work = 1'b1;
        step(50);
        check("resume_s", int'(sec), 2);
        step(53800);
        check_time("t10m", 0, 10, 0);

        // Start ignored while working; abort alone in ACCUM does nothing.
        start = 1'b1;
        step(1);
        start = 1'b0; work = 1'b0;
        check("start_busy", int'(cln), 0);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("abort_idle", int'(cln), 0);

        // Start together with abort in ACCUM starts cleaning.
        start = 1'b1; abort = 1'b1;
        step(1);
        start = 1'b0; abort = 1'b0;
        check("cl_on", int'(cln), 1);
        check("cl_rem", int'(remain), 180);

        // Restart request ignored in CLEAN; working time frozen.
        start = 1'b1; work = 1'b1;
        step(1);
        start = 1'b0;
        check("restart_rem", int'(remain), 180);
        step(999);
        check("rem170", int'(remain), 170);
        check_time("frozen", 0, 10, 0);
        abort = 1'b1;
        step(1);
        abort = 1'b0; work = 1'b0;
        check("ab_cln", int'(cln), 0);
        check("ab_rem", int'(remain), 0);
        check("ab_done", int'(done), 0);
        check_time("ab_time", 0, 10, 0);

        // Full clean run to completion.
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("full_rem", int'(remain), 180);
        step(17999);
        check("full_rem1", int'(remain), 1);
        check("full_pre_done", int'(done), 0);
        step(1);
        check("full_done", int'(done), 1);
        check("full_cln", int'(cln), 0);
        check("full_rem0", int'(remain), 0);
        check_time("full_time", 0, 0, 0);
        step(1);
        check("done_pulse", int'(done), 0);

        // Reset mid-clean.
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("rc_cln", int'(cln), 1);
        step(50);
        rst = 1'b1;
        step(1);
        check("rc_cln0", int'(cln), 0);
        check("rc_rem0", int'(remain), 0);
        check("rc_done0", int'(done), 0);
        check_time("rc_time", 0, 0, 0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
